// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bus: two write-back producers, the claim port, the hazard queries
// and the register-file write port.
interface regfile_wb_scheduler_if;
  logic        valid_a;
  logic [4:0]  reg_a;
  logic [63:0] data_a;
  logic        ready_a;
  logic        valid_b;
  logic [4:0]  reg_b;
  logic [63:0] data_b;
  logic        ready_b;
  logic        claim_valid;
  logic [4:0]  claim_reg;
  logic        claim_ready;
  logic [4:0]  query_a;
  logic [4:0]  query_b;
  logic        hazard_a;
  logic        hazard_b;
  logic [4:0]  rw;
  logic [63:0] bus_w;
  logic        reg_wr;

  modport master (
    output valid_a, reg_a, data_a, valid_b, reg_b, data_b,
    output claim_valid, claim_reg, query_a, query_b,
    input  ready_a, ready_b, claim_ready, hazard_a, hazard_b, rw, bus_w, reg_wr
  );

  modport slave (
    input  valid_a, reg_a, data_a, valid_b, reg_b, data_b,
    input  claim_valid, claim_reg, query_a, query_b,
    output ready_a, ready_b, claim_ready, hazard_a, hazard_b, rw, bus_w, reg_wr
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register-file write port with a pending-write scoreboard
// used by issue logic for destination claims and read-after-write hazard detection.
module regfile_wb_scheduler (
  input  logic                  clk_i,
  input  logic                  rst_i,
  regfile_wb_scheduler_if.slave wb
);
  localparam logic [4:0] ZeroReg = 5'd31;

  logic        last_a_q, last_a_d;  // 1: port A won the most recent transfer
  logic        reg_wr_q, reg_wr_d;
  logic [4:0]  rw_q, rw_d;
  logic [63:0] bus_w_q, bus_w_d;
  logic [31:0] busy_q, busy_d;

  logic        grant_a, grant_b, xfer, claim_fire;
  logic [4:0]  sel_reg;
  logic [63:0] sel_data;

  always_comb begin
    grant_a    = wb.valid_a && (!wb.valid_b || !last_a_q);
    grant_b    = wb.valid_b && !grant_a;
    xfer       = grant_a || grant_b;
    sel_reg    = grant_a ? wb.reg_a : wb.reg_b;
    sel_data   = grant_a ? wb.data_a : wb.data_b;
    claim_fire = wb.claim_valid && ((wb.claim_reg == ZeroReg) || !busy_q[wb.claim_reg]);
  end

  assign wb.ready_a     = grant_a;
  assign wb.ready_b     = grant_b;
  assign wb.claim_ready = claim_fire;
  assign wb.hazard_a    = busy_q[wb.query_a];
  assign wb.hazard_b    = busy_q[wb.query_b];
  assign wb.rw          = rw_q;
  assign wb.bus_w       = bus_w_q;
  assign wb.reg_wr      = reg_wr_q;

  always_comb begin
    last_a_d = xfer ? grant_a : last_a_q;
    reg_wr_d = xfer && (sel_reg != ZeroReg);
    rw_d     = xfer ? sel_reg : rw_q;
    bus_w_d  = xfer ? sel_data : bus_w_q;
    busy_d   = busy_q;
    // Clear before set so a same-cycle claim of the landing register wins.
    if (reg_wr_q) busy_d[rw_q] = 1'b0;
    if (claim_fire) busy_d[wb.claim_reg] = 1'b1;
    busy_d[ZeroReg] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_a_q <= 1'b0;
      reg_wr_q <= 1'b0;
      rw_q     <= '0;
      bus_w_q  <= '0;
      busy_q   <= '0;
    end else begin
      last_a_q <= last_a_d;
      reg_wr_q <= reg_wr_d;
      rw_q     <= rw_d;
      bus_w_q  <= bus_w_d;
      busy_q   <= busy_d;
    end
  end
endmodule
